// File: rtl/lfm_phase_gen_if.sv
// ---------------------------------------------------------------------------
// lfm_phase_gen_if
// Purpose : groups the control/data signals between a burst requester and
//           the LFM sample-address generator.
// Signals : START        - one-cycle burst request (to generator)
//           F_START      - initial phase increment (to generator)
//           F_STEP       - per-sample increment delta, two's complement
//           NUM_SAMPLES  - burst length in samples (to generator)
//           OUT_READY    - READY from the output register (to generator)
//           ROM_ADDR     - sine ROM address (from generator)
//           SIGN_LFM_START_CALC / SIGN_LFM_STOP_CALC - burst framing pulses
//           BUSY         - generator busy with a burst
//           ERR          - rejected zero-length request pulse
// Modports: master drives requests, slave is the generator.
// ---------------------------------------------------------------------------
interface lfm_phase_gen_if #(
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int CNT_WIDTH   = 16
);
  logic                   START;
  logic [PHASE_WIDTH-1:0] F_START;
  logic [PHASE_WIDTH-1:0] F_STEP;
  logic [CNT_WIDTH-1:0]   NUM_SAMPLES;
  logic                   OUT_READY;
  logic [ADDR_WIDTH-1:0]  ROM_ADDR;
  logic                   SIGN_LFM_START_CALC;
  logic                   SIGN_LFM_STOP_CALC;
  logic                   BUSY;
  logic                   ERR;

  modport master (
    output START, F_START, F_STEP, NUM_SAMPLES, OUT_READY,
    input  ROM_ADDR, SIGN_LFM_START_CALC, SIGN_LFM_STOP_CALC, BUSY, ERR
  );

  modport slave (
    input  START, F_START, F_STEP, NUM_SAMPLES, OUT_READY,
    output ROM_ADDR, SIGN_LFM_START_CALC, SIGN_LFM_STOP_CALC, BUSY, ERR
  );
endinterface

// File: rtl/lfm_phase_gen.sv
// ---------------------------------------------------------------------------
// lfm_phase_gen
// Purpose : chirp (LFM) sine-ROM address generator. A 32-bit phase
//           accumulator is advanced by an increment that itself grows by
//           F_STEP every sample; the top ADDR_WIDTH phase bits address the
//           ROM once per clock. Each burst is framed by START/STOP pulses.
// Ports   : CLK   - system clock, rising edge
//           RESET - asynchronous, active-high reset
//           bus   - lfm_phase_gen_if.slave (request inputs, ROM address,
//                   framing pulses, BUSY, ERR)
// ---------------------------------------------------------------------------
module lfm_phase_gen #(
  parameter int PHASE_WIDTH  = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int CNT_WIDTH    = 16,
  parameter int GUARD_CYCLES = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  lfm_phase_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_WAIT
  } state_t;

  localparam int                    GW        = $clog2(GUARD_CYCLES + 1) + 1;
  localparam logic [GW-1:0]         GUARD_LIM = GW'(GUARD_CYCLES);
  localparam logic [GW-1:0]         GUARD_ONE = GW'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

  state_t                  r_state, w_state_next;
  logic [PHASE_WIDTH-1:0]  r_phase, w_phase_next;
  logic [PHASE_WIDTH-1:0]  r_inc, w_inc_next;
  logic [PHASE_WIDTH-1:0]  r_step, w_step_next;
  logic [CNT_WIDTH-1:0]    r_num, w_num_next;
  logic [CNT_WIDTH-1:0]    r_cnt, w_cnt_next;
  logic [GW-1:0]           r_guard, w_guard_next;
  logic [ADDR_WIDTH-1:0]   r_rom_addr, w_rom_addr_next;
  logic                    r_start_calc, w_start_calc_next;
  logic                    r_stop_calc, w_stop_calc_next;
  logic                    r_busy, w_busy_next;
  logic                    r_err, w_err_next;

  // A sample is emitted on the edge leaving LOAD (sample 0) and on every
  // RUN edge until the counter reaches the burst length.
  logic w_emit;
  assign w_emit = (r_state == ST_LOAD) || ((r_state == ST_RUN) && (r_cnt != r_num));

  always_comb begin
    w_state_next      = r_state;
    w_phase_next      = r_phase;
    w_inc_next        = r_inc;
    w_step_next       = r_step;
    w_num_next        = r_num;
    w_cnt_next        = r_cnt;
    w_guard_next      = r_guard;
    w_rom_addr_next   = r_rom_addr;
    w_start_calc_next = 1'b0;
    w_stop_calc_next  = 1'b0;
    w_busy_next       = r_busy;
    w_err_next        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_rom_addr_next = '0;
        if (bus.START && bus.OUT_READY) begin
          if (bus.NUM_SAMPLES != '0) begin
            // Accumulator is primed here so LOAD can already emit sample 0
            // on its outgoing edge.
            w_state_next = ST_LOAD;
            w_busy_next  = 1'b1;
            w_phase_next = '0;
            w_inc_next   = bus.F_START;
            w_step_next  = bus.F_STEP;
            w_num_next   = bus.NUM_SAMPLES;
            w_cnt_next   = '0;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        w_state_next = ST_RUN;
      end

      ST_RUN: begin
        if (r_cnt == r_num) begin
          w_state_next = ST_WAIT;
          w_guard_next = '0;
        end
      end

      ST_WAIT: begin
        if ((r_guard >= GUARD_LIM) && bus.OUT_READY) begin
          w_state_next    = ST_IDLE;
          w_busy_next     = 1'b0;
          w_rom_addr_next = '0;
        end else if (r_guard < GUARD_LIM) begin
          w_guard_next = r_guard + GUARD_ONE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_emit) begin
      w_rom_addr_next   = r_phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
      w_start_calc_next = (r_cnt == '0);
      w_stop_calc_next  = (r_cnt == (r_num - CNT_ONE));
      // Modulo-2^N wrap of phase and increment is intentional (down-chirps).
      w_phase_next      = r_phase + r_inc;
      w_inc_next        = r_inc + r_step;
      w_cnt_next        = r_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_phase      <= '0;
      r_inc        <= '0;
      r_step       <= '0;
      r_num        <= '0;
      r_cnt        <= '0;
      r_guard      <= '0;
      r_rom_addr   <= '0;
      r_start_calc <= 1'b0;
      r_stop_calc  <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_phase      <= w_phase_next;
      r_inc        <= w_inc_next;
      r_step       <= w_step_next;
      r_num        <= w_num_next;
      r_cnt        <= w_cnt_next;
      r_guard      <= w_guard_next;
      r_rom_addr   <= w_rom_addr_next;
      r_start_calc <= w_start_calc_next;
      r_stop_calc  <= w_stop_calc_next;
      r_busy       <= w_busy_next;
      r_err        <= w_err_next;
    end
  end

  assign bus.ROM_ADDR            = r_rom_addr;
  assign bus.SIGN_LFM_START_CALC = r_start_calc;
  assign bus.SIGN_LFM_STOP_CALC  = r_stop_calc;
  assign bus.BUSY                = r_busy;
  assign bus.ERR                 = r_err;

endmodule

// File: tb/tb_lfm_phase_gen.sv
// ---------------------------------------------------------------------------
// tb_lfm_phase_gen
// Self-checking bench: a cycle-timeline model of the chirp generator predicts
// every output each cycle; directed bursts pin the model with literal ROM
// address sequences; randomized traffic and an output-register READY
// emulation exercise back-to-back bursts.
// ---------------------------------------------------------------------------
module tb_lfm_phase_gen;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  lfm_phase_gen_if bus ();

  lfm_phase_gen dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  logic ready_drv = 1'b1;
  logic ready_emu = 1'b1;
  logic emu_mode  = 1'b0;
  assign bus.OUT_READY = emu_mode ? ready_emu : ready_drv;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit done     = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model (timeline based) ----------------
  bit             m_busy = 1'b0;
  int             m_t    = 0;
  int             m_n    = 0;
  logic [11:0]    m_addrs[$];
  logic [11:0]    e_addr = '0;
  logic           e_sc = 1'b0, e_st = 1'b0, e_busy = 1'b0, e_err = 1'b0;

  task automatic model_step();
    logic [31:0] ph, inc;
    int d, k;
    if (RESET) begin
      m_busy = 1'b0;
      e_addr = '0; e_sc = 1'b0; e_st = 1'b0; e_busy = 1'b0; e_err = 1'b0;
      cyc++;
      return;
    end
    e_err = 1'b0;
    if (!m_busy) begin
      if (bus.START && bus.OUT_READY) begin
        if (bus.NUM_SAMPLES == 16'd0) begin
          e_err = 1'b1;
        end else begin
          m_busy = 1'b1;
          m_t    = cyc;
          m_n    = int'(bus.NUM_SAMPLES);
          m_addrs.delete();
          ph  = 32'd0;
          inc = bus.F_START;
          for (int i = 0; i < m_n; i++) begin
            m_addrs.push_back(ph[31:20]);
            ph  = ph + inc;
            inc = inc + bus.F_STEP;
          end
        end
      end
    end else if ((cyc >= m_t + m_n + 4) && bus.OUT_READY) begin
      // third WAIT cycle onward: guard elapsed, READY honoured
      m_busy = 1'b0;
    end
    d = cyc + 1;
    e_busy = m_busy;
    e_sc = 1'b0; e_st = 1'b0; e_addr = '0;
    if (m_busy) begin
      k = d - (m_t + 2);
      if (k >= 0 && k < m_n) begin
        e_addr = m_addrs[k];
        e_sc   = (k == 0);
        e_st   = (k == m_n - 1);
      end else if (k >= m_n) begin
        e_addr = m_addrs[m_n - 1];
      end
    end
    cyc++;
  endtask

  initial begin
    forever begin
      @(posedge CLK or posedge RESET);
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge CLK);
      if (!done)
        chk("cycle_outputs",
            64'({bus.ROM_ADDR, bus.SIGN_LFM_START_CALC, bus.SIGN_LFM_STOP_CALC, bus.BUSY, bus.ERR}),
            64'({e_addr, e_sc, e_st, e_busy, e_err}));
    end
  end

  // ---------------- output-register READY emulation ----------------
  logic s_sc, s_st;
  int   rise_cnt = 0;
  initial begin
    forever begin
      @(negedge CLK);
      s_sc = bus.SIGN_LFM_START_CALC;
      s_st = bus.SIGN_LFM_STOP_CALC;
      @(posedge CLK);
      #1;
      if (RESET || !emu_mode) begin
        ready_emu = 1'b1;
        rise_cnt  = 0;
      end else begin
        if (s_sc) ready_emu = 1'b0;
        if (s_st) rise_cnt = 3;
        else if (rise_cnt > 0) begin
          rise_cnt--;
          if (rise_cnt == 0) ready_emu = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] fs, input logic [31:0] fst, input logic [15:0] n);
    bus.F_START     = fs;
    bus.F_STEP      = fst;
    bus.NUM_SAMPLES = n;
    bus.START       = 1'b1;
    tick();
    bus.START = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (bus.BUSY && i < 200) begin
      tick();
      i++;
    end
    if (bus.BUSY) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout: BUSY still 1 after 200 cycles, required 0");
    end
    tick();
  endtask

  task automatic run_lit(input string nm, input logic [31:0] fs, input logic [31:0] fst,
                         input int n, input logic [11:0] ex [5]);
    pulse_start(fs, fst, 16'(n));
    chk({nm, "_load"}, 64'({bus.BUSY, bus.ROM_ADDR}), 64'({1'b1, 12'd0}));
    tick();
    for (int k = 0; k < n; k++) begin
      chk(nm, 64'({bus.ROM_ADDR, bus.SIGN_LFM_START_CALC, bus.SIGN_LFM_STOP_CALC}),
          64'({ex[k], 1'(k == 0), 1'(k == n - 1)}));
      tick();
    end
    wait_idle();
  endtask

  int t0, p0, lim;

  initial begin
    bus.START       = 1'b0;
    bus.F_START     = '0;
    bus.F_STEP      = '0;
    bus.NUM_SAMPLES = '0;
    repeat (3) tick();
    RESET = 1'b0;
    repeat (5) tick();
    chk("reset_idle", 64'({bus.ROM_ADDR, bus.SIGN_LFM_START_CALC, bus.SIGN_LFM_STOP_CALC, bus.BUSY, bus.ERR}), 64'(0));

    run_lit("const_inc", 32'h0010_0000, 32'h0, 4, '{12'd0, 12'd1, 12'd2, 12'd3, 12'd0});
    run_lit("chirp",     32'h0,         32'h0010_0000, 5, '{12'd0, 12'd0, 12'd1, 12'd3, 12'd6});
    run_lit("wrap_down", 32'hFFF0_0000, 32'h0, 3, '{12'd0, 12'd4095, 12'd4094, 12'd0, 12'd0});

    // N=1 with READY held low in WAIT
    pulse_start(32'h0010_0000, 32'h0, 16'd1);
    tick();
    chk("n1_both_pulses", 64'({bus.SIGN_LFM_START_CALC, bus.SIGN_LFM_STOP_CALC}), 64'(2'b11));
    ready_drv = 1'b0;
    repeat (10) tick();
    chk("wait_hold_busy", 64'(bus.BUSY), 64'(1));
    ready_drv = 1'b1;
    tick();
    chk("wait_release", 64'(bus.BUSY), 64'(0));
    tick();

    // zero-length request
    pulse_start(32'h1234_5678, 32'h0, 16'd0);
    chk("err_pulse", 64'({bus.ERR, bus.BUSY}), 64'(2'b10));
    tick();
    chk("err_one_cycle", 64'({bus.ERR, bus.BUSY}), 64'(0));

    // request while READY low is silently ignored
    ready_drv = 1'b0;
    pulse_start(32'h0010_0000, 32'h0, 16'd5);
    chk("notready_ignored", 64'({bus.ERR, bus.BUSY}), 64'(0));
    tick();
    chk("notready_idle", 64'(bus.BUSY), 64'(0));
    ready_drv = 1'b1;
    tick();

    // second START during RUN must not change burst length
    t0 = cyc;
    pulse_start(32'h0003_0000, 32'h0001_0000, 16'd6);
    tick();
    bus.NUM_SAMPLES = 16'd2;
    bus.START       = 1'b1;
    tick();
    bus.START = 1'b0;
    lim = 0;
    while (!bus.SIGN_LFM_STOP_CALC && lim < 50) begin tick(); lim++; end
    chk("restart_ignored_len", 64'(cyc - t0), 64'(7));
    wait_idle();

    // asynchronous reset in the middle of RUN
    pulse_start(32'h0010_0000, 32'h0, 16'd10);
    repeat (4) tick();
    #2;
    RESET = 1'b1;
    #1;
    chk("async_reset", 64'({bus.ROM_ADDR, bus.SIGN_LFM_START_CALC, bus.SIGN_LFM_STOP_CALC, bus.BUSY, bus.ERR}), 64'(0));
    tick();
    RESET = 1'b0;
    tick();
    run_lit("after_reset", 32'h0010_0000, 32'h0, 4, '{12'd0, 12'd1, 12'd2, 12'd3, 12'd0});

    // back-to-back bursts against an output-register style READY
    emu_mode        = 1'b1;
    bus.F_START     = 32'h0010_0000;
    bus.F_STEP      = 32'h0;
    bus.NUM_SAMPLES = 16'd3;
    bus.START       = 1'b1;
    lim = 0;
    while (!bus.SIGN_LFM_STOP_CALC && lim < 50) begin tick(); lim++; end
    p0 = cyc;
    tick();
    lim = 0;
    while (!bus.SIGN_LFM_START_CALC && lim < 50) begin tick(); lim++; end
    chk("b2b_gap", 64'(cyc - p0), 64'(7));
    for (int i = 0; i < 300; i++) begin
      bus.F_START     = $urandom;
      bus.F_STEP      = $urandom;
      bus.NUM_SAMPLES = 16'($urandom_range(1, 10));
      tick();
    end
    bus.START = 1'b0;
    wait_idle();
    emu_mode = 1'b0;
    tick();

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      bus.START       = ($urandom_range(0, 5) == 0);
      bus.NUM_SAMPLES = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      bus.F_START     = $urandom;
      bus.F_STEP      = $urandom;
      ready_drv       = ($urandom_range(0, 3) != 0);
      if (i % 700 == 350) begin
        #3;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
      end else begin
        tick();
      end
    end
    bus.START = 1'b0;
    ready_drv = 1'b1;
    wait_idle();

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
